// File: rtl/layer_compositor.sv
// Sprite layer compositor: priority mux over NUM_LAYERS layers plus background,
// with a 2-cycle pixel pipeline and a per-frame sprite collision report.
module layer_compositor #(
    parameter int                   NUM_LAYERS = 4,
    parameter int                   COLOR_W    = 12,
    parameter logic [COLOR_W-1:0]   KEY_COLOR  = 12'hF0F,
    parameter int                   CNT_W      = 19
) (
    input  logic                            clk,
    input  logic                            clrn,
    input  logic                            video_on,
    input  logic                            frame_tick,
    input  logic [NUM_LAYERS-1:0]           layer_on,
    input  logic [NUM_LAYERS*COLOR_W-1:0]   layer_color,
    input  logic                            bg_on,
    input  logic [COLOR_W-1:0]              bg_color,
    input  logic [NUM_LAYERS-1:0]           cfg_layer_en,
    input  logic                            cfg_key_en,
    output logic [COLOR_W-1:0]              rgb_out,
    output logic                            video_on_out,
    output logic                            coll_valid,
    output logic [NUM_LAYERS-1:0]           coll_mask,
    output logic [CNT_W-1:0]                coll_count,
    output logic                            coll_overrun,
    input  logic                            coll_ack
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    function automatic logic two_or_more(input logic [NUM_LAYERS-1:0] h);
        int n;
        n = 0;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (h[i]) n++;
        return (n >= 2);
    endfunction

    logic [NUM_LAYERS-1:0]         en_sh_q;
    logic                          key_sh_q;

    logic                          vid_p1_q;
    logic [NUM_LAYERS-1:0]         on_p1_q;
    logic [NUM_LAYERS*COLOR_W-1:0] col_p1_q;
    logic                          bgon_p1_q;
    logic [COLOR_W-1:0]            bgcol_p1_q;

    logic [COLOR_W-1:0]            rgb_p2_q;
    logic                          vid_p2_q;

    logic [NUM_LAYERS-1:0]         acc_mask_q;
    logic [CNT_W-1:0]              acc_cnt_q;
    logic                          valid_q;
    logic                          overrun_q;
    logic [NUM_LAYERS-1:0]         mask_q;
    logic [CNT_W-1:0]              count_q;

    logic [NUM_LAYERS-1:0]         hit_p1;
    logic [COLOR_W-1:0]            rgb_d;
    logic                          ovl_p1;
    logic [NUM_LAYERS-1:0]         mask_d;
    logic [CNT_W-1:0]              cnt_d;

    // Stage 1 -> stage 2: effective hits use the shadow config of the current frame
    always_comb begin
        logic found;
        hit_p1 = '0;
        rgb_d  = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            hit_p1[i] = on_p1_q[i] & en_sh_q[i] &
                        ~(key_sh_q & (col_p1_q[i*COLOR_W +: COLOR_W] == KEY_COLOR));
        end
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (hit_p1[i] && !found) begin
                rgb_d = col_p1_q[i*COLOR_W +: COLOR_W];
                found = 1'b1;
            end
        end
        if (!found && bgon_p1_q)
            rgb_d = bgcol_p1_q;
        if (!vid_p1_q)
            rgb_d = '0;
    end

    // The stage-1 pixel folds into whichever report is being formed this cycle
    always_comb begin
        ovl_p1 = vid_p1_q & two_or_more(hit_p1);
        mask_d = acc_mask_q | (ovl_p1 ? hit_p1 : '0);
        cnt_d  = sat_inc(acc_cnt_q, ovl_p1);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            en_sh_q    <= '1;
            key_sh_q   <= 1'b0;
            vid_p1_q   <= 1'b0;
            on_p1_q    <= '0;
            col_p1_q   <= '0;
            bgon_p1_q  <= 1'b0;
            bgcol_p1_q <= '0;
            rgb_p2_q   <= '0;
            vid_p2_q   <= 1'b0;
        end else begin
            if (frame_tick) begin
                en_sh_q  <= cfg_layer_en;
                key_sh_q <= cfg_key_en;
            end
            vid_p1_q   <= video_on;
            on_p1_q    <= layer_on;
            col_p1_q   <= layer_color;
            bgon_p1_q  <= bg_on;
            bgcol_p1_q <= bg_color;
            rgb_p2_q   <= rgb_d;
            vid_p2_q   <= vid_p1_q;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            acc_mask_q <= '0;
            acc_cnt_q  <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            mask_q     <= '0;
            count_q    <= '0;
        end else if (frame_tick) begin
            mask_q     <= mask_d;
            count_q    <= cnt_d;
            acc_mask_q <= '0;
            acc_cnt_q  <= '0;
            valid_q    <= 1'b1;
            // Overwriting an unacknowledged report is sticky until acknowledged
            overrun_q  <= ~coll_ack & (valid_q | overrun_q);
        end else begin
            acc_mask_q <= mask_d;
            acc_cnt_q  <= cnt_d;
            if (coll_ack && valid_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign rgb_out      = rgb_p2_q;
    assign video_on_out = vid_p2_q;
    assign coll_valid   = valid_q;
    assign coll_mask    = mask_q;
    assign coll_count   = count_q;
    assign coll_overrun = overrun_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed scenarios plus random pixels, checked
// against a frame-level behavioural model of the compositor.
module tb_layer_compositor;
    localparam int NL = 4;
    localparam int CW = 12;
    localparam logic [CW-1:0] KEY = 12'hF0F;
    localparam int CNTW = 19;

    logic clk = 1'b0;
    logic clrn;
    logic video_on, frame_tick, bg_on, cfg_key_en, coll_ack;
    logic [NL-1:0] layer_on, cfg_layer_en;
    logic [NL*CW-1:0] layer_color;
    logic [CW-1:0] bg_color;
    logic [CW-1:0] rgb_out;
    logic video_on_out, coll_valid, coll_overrun;
    logic [NL-1:0] coll_mask;
    logic [CNTW-1:0] coll_count;

    int tests = 0;
    int fails = 0;

    // model state
    logic [NL-1:0] m_en;
    logic          m_key;
    logic [NL-1:0] m_acc_mask, m_mask;
    int            m_acc_cnt, m_cnt;
    logic          m_valid, m_ovr;
    logic [CW-1:0] exp_rgb_prev;
    logic          exp_vid_prev;

    always #5 clk = ~clk;

    layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .KEY_COLOR(KEY), .CNT_W(CNTW)) dut (
        .clk(clk), .clrn(clrn), .video_on(video_on), .frame_tick(frame_tick),
        .layer_on(layer_on), .layer_color(layer_color), .bg_on(bg_on), .bg_color(bg_color),
        .cfg_layer_en(cfg_layer_en), .cfg_key_en(cfg_key_en),
        .rgb_out(rgb_out), .video_on_out(video_on_out), .coll_valid(coll_valid),
        .coll_mask(coll_mask), .coll_count(coll_count), .coll_overrun(coll_overrun),
        .coll_ack(coll_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = '1; m_key = 1'b0;
        m_acc_mask = '0; m_acc_cnt = 0;
        m_mask = '0; m_cnt = 0; m_valid = 1'b0; m_ovr = 1'b0;
        exp_rgb_prev = '0; exp_vid_prev = 1'b0;
    endtask

    function automatic logic [CW-1:0] lcol(input int i);
        return layer_color[i*CW +: CW];
    endfunction

    // One pixel: update the model, clock it in, check everything observable.
    task automatic step();
        logic [NL-1:0] hits;
        logic [CW-1:0] px;
        int n;
        if (frame_tick) begin
            m_ovr   = !coll_ack && (m_valid || m_ovr);
            m_valid = 1'b1;
            m_mask  = m_acc_mask;
            m_cnt   = m_acc_cnt;
            m_acc_mask = '0;
            m_acc_cnt  = 0;
            m_en  = cfg_layer_en;
            m_key = cfg_key_en;
        end else if (coll_ack && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        n = 0;
        px = '0;
        for (int i = 0; i < NL; i++) begin
            hits[i] = layer_on[i] && m_en[i] && !(m_key && lcol(i) == KEY);
            if (hits[i]) n++;
        end
        for (int i = NL - 1; i >= 0; i--)
            if (hits[i]) px = lcol(i);
        if (n == 0 && bg_on) px = bg_color;
        if (!video_on) px = '0;
        if (video_on && n >= 2) begin
            m_acc_mask |= hits;
            if (m_acc_cnt < (1 << CNTW) - 1) m_acc_cnt++;
        end
        @(posedge clk);
        #1;
        chk("rgb", 32'(rgb_out), 32'(exp_rgb_prev));
        chk("vid_out", 32'(video_on_out), 32'(exp_vid_prev));
        chk("valid", 32'(coll_valid), 32'(m_valid));
        chk("overrun", 32'(coll_overrun), 32'(m_ovr));
        chk("mask", 32'(coll_mask), 32'(m_mask));
        chk("count", 32'(coll_count), 32'(m_cnt));
        exp_rgb_prev = px;
        exp_vid_prev = video_on;
        frame_tick = 1'b0;
        coll_ack   = 1'b0;
    endtask

    task automatic set_layer(input int i, input logic [CW-1:0] c);
        layer_color[i*CW +: CW] = c;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rgb"}, 32'(rgb_out), 0);
        chk({tag, "_vid"}, 32'(video_on_out), 0);
        chk({tag, "_valid"}, 32'(coll_valid), 0);
        chk({tag, "_mask"}, 32'(coll_mask), 0);
        chk({tag, "_count"}, 32'(coll_count), 0);
        chk({tag, "_ovr"}, 32'(coll_overrun), 0);
    endtask

    initial begin
        clrn = 1'b0;
        video_on = 0; frame_tick = 0; bg_on = 0; cfg_key_en = 0; coll_ack = 0;
        layer_on = '0; cfg_layer_en = '1; layer_color = '0; bg_color = '0;
        model_reset();
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        clrn = 1'b1;

        // priority: layer 1 wins over layer 2, then background
        video_on = 1; layer_on = 4'b0110;
        set_layer(1, 12'h0F0); set_layer(2, 12'hF00);
        step();
        layer_on = '0; bg_on = 1; bg_color = 12'h00F;
        step();
        chk("prio_layer1", 32'(rgb_out), 32'h0F0);
        step();
        chk("prio_bg", 32'(rgb_out), 32'h00F);

        // colour key only takes effect after frame_tick
        layer_on = 4'b0001; set_layer(0, KEY); bg_color = 12'h123; cfg_key_en = 1;
        step();
        step();
        chk("key_pre_tick", 32'(rgb_out), 32'hF0F);
        frame_tick = 1;
        step();
        step();
        chk("key_post_tick", 32'(rgb_out), 32'h123);

        // collision frame: ack with tick starts a clean report, then 5 overlaps
        cfg_key_en = 0; video_on = 0; frame_tick = 1; coll_ack = 1;
        step();
        chk("tick_ack_valid", 32'(coll_valid), 1);
        chk("tick_ack_ovr", 32'(coll_overrun), 0);
        video_on = 1;
        set_layer(0, 12'h111); set_layer(3, 12'h333); set_layer(1, 12'h0F0);
        layer_on = 4'b1001;
        repeat (5) step();
        layer_on = 4'b0010;
        repeat (2) step();
        video_on = 0; frame_tick = 1; coll_ack = 1;
        step();
        chk("coll_valid", 32'(coll_valid), 1);
        chk("coll_mask", 32'(coll_mask), 32'b1001);
        chk("coll_count", 32'(coll_count), 5);

        // overrun: second tick without ack shows the second frame's data
        video_on = 1; layer_on = 4'b0110; set_layer(2, 12'h222);
        repeat (3) step();
        video_on = 0; frame_tick = 1;
        step();
        chk("ovr_set", 32'(coll_overrun), 1);
        chk("ovr_mask", 32'(coll_mask), 32'b0110);
        chk("ovr_count", 32'(coll_count), 3);
        coll_ack = 1;
        step();
        chk("ack_valid", 32'(coll_valid), 0);
        chk("ack_ovr", 32'(coll_overrun), 0);
        chk("ack_hold_count", 32'(coll_count), 3);
        coll_ack = 1;
        step();
        chk("ack_idle_valid", 32'(coll_valid), 0);
        frame_tick = 1; step();
        frame_tick = 1; step();
        chk("ovr_again", 32'(coll_overrun), 1);
        frame_tick = 1; coll_ack = 1; step();
        chk("coinc_valid", 32'(coll_valid), 1);
        chk("coinc_ovr", 32'(coll_overrun), 0);

        // blanking: all layers hit while video off
        video_on = 0; layer_on = 4'b1111;
        step(); step();
        chk("blank_rgb", 32'(rgb_out), 0);
        frame_tick = 1; step();
        chk("blank_count", 32'(coll_count), 0);

        // disabled layer 0 ignored for pixel and collision
        cfg_layer_en = 4'b1110; layer_on = 4'b0000; frame_tick = 1; step();
        video_on = 1; layer_on = 4'b0011; set_layer(0, 12'hAAA); set_layer(1, 12'h0F0);
        step(); step();
        chk("en_rgb", 32'(rgb_out), 32'h0F0);
        video_on = 0; frame_tick = 1; step();
        chk("en_count", 32'(coll_count), 0);
        chk("en_mask", 32'(coll_mask), 0);
        cfg_layer_en = 4'b1111; frame_tick = 1; step();

        // reset mid-frame after 3 overlap pixels
        video_on = 1; layer_on = 4'b0101; set_layer(0, 12'h10A); set_layer(2, 12'h20B);
        repeat (3) step();
        #2 clrn = 1'b0;
        #1;
        check_zero_outputs("midreset");
        model_reset();
        video_on = 0; layer_on = '0;
        @(negedge clk);
        clrn = 1'b1;
        frame_tick = 1;
        step();
        chk("post_reset_count", 32'(coll_count), 0);
        chk("post_reset_valid", 32'(coll_valid), 1);

        // random traffic
        for (int t = 0; t < 600; t++) begin
            video_on = ($urandom_range(0, 7) != 0);
            layer_on = NL'($urandom);
            for (int i = 0; i < NL; i++)
                set_layer(i, ($urandom_range(0, 3) == 0) ? KEY : CW'($urandom));
            bg_on = $urandom_range(0, 1);
            bg_color = CW'($urandom);
            cfg_layer_en = NL'($urandom);
            cfg_key_en = $urandom_range(0, 1);
            frame_tick = ($urandom_range(0, 15) == 0);
            coll_ack = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
